// File: rtl/div_unit_pkg.sv
// Shared divider definitions: latency contract, operand signedness,
// result classification and the divider FSM encoding.
package div_unit_pkg;

   localparam int DIV_LATENCY        = 12;
   localparam int DIV_BITS_PER_CYCLE = 3;

   typedef enum logic {
      unsigned_op = 1'b0,
      signed_op   = 1'b1
   } sign_t;

   typedef enum logic [1:0] {
      normal_div   = 2'd0,
      normal_rem   = 2'd1,
      div_by_0_div = 2'd2,
      overflow_div = 2'd3
   } div_out_case_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One radix-8 iteration: three chained restoring subtract/shift steps,
// consuming dividend bits MSB first and producing three quotient bits.
module div_step_r8 #(
   parameter int W = 33
) (
   input  logic [W-1:0] rem,
   input  logic [2:0]   dbits,
   input  logic [W-1:0] dsr,
   output logic [W-1:0] rem_next,
   output logic [2:0]   qbits
);

   logic [W-1:0] part_s;
   logic [W:0]   trial_s;

   // Partial remainder stays below the divisor, so the top trial bit drops out after restore.
   always_comb begin
      part_s  = rem;
      trial_s = {(W+1){1'b0}};
      qbits   = 3'b000;
      for (int i = 2; i >= 0; i--) begin
         trial_s = {part_s, dbits[i]};
         if (trial_s >= {1'b0, dsr}) begin
            trial_s  = trial_s - {1'b0, dsr};
            qbits[i] = 1'b1;
         end else begin
            qbits[i] = 1'b0;
         end
         part_s = trial_s[W-1:0];
      end
      rem_next = part_s;
   end

endmodule

// File: rtl/div_unit.sv
// Fixed-latency iterative RV32M divider: FSM, operand latches, special-case
// classification and final sign fix / quotient-remainder select.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  sign_t           sign,
   input  logic            rem_sel,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int ITERS = (XLEN + BITS_PER_CYCLE) / BITS_PER_CYCLE;

   div_state_t    state_r, state_nxt_s;
   logic [3:0]    cnt_r;
   logic [XLEN:0] rem_r, quo_r, dsr_r;
   logic [XLEN-1:0] dvd_r, result_r;
   logic          neg_q_r, neg_r_r, rem_sel_r, busy_r, done_r;
   div_out_case_t case_r, case_s;

   logic          accept_s, last_s, dvd_neg_s, dsr_neg_s;
   logic [XLEN:0] dvd_mag_s, dsr_mag_s, step_rem_s, quo_nxt_s;
   logic [2:0]    step_q_s;
   logic [XLEN-1:0] q_fix_s, r_fix_s, res_s;

   div_step_r8 #(.W(XLEN + 1)) u_step (
      .rem      (rem_r),
      .dbits    (quo_r[XLEN -: 3]),
      .dsr      (dsr_r),
      .rem_next (step_rem_s),
      .qbits    (step_q_s)
   );

   // Accept decision, operand magnitudes and special-case classification.
   always_comb begin
      if (!flush && start && (state_r == IDLE || state_r == FIN)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      last_s    = (state_r == RUN) && (cnt_r == 4'd1);
      dvd_neg_s = (sign == signed_op) && dividend[XLEN-1];
      dsr_neg_s = (sign == signed_op) && divisor[XLEN-1];
      dvd_mag_s = dvd_neg_s ? {1'b0, -dividend} : {1'b0, dividend};
      dsr_mag_s = dsr_neg_s ? {1'b0, -divisor}  : {1'b0, divisor};
      if (divisor == {XLEN{1'b0}}) begin
         case_s = div_by_0_div;
      end else if ((sign == signed_op) && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                   && (divisor == {XLEN{1'b1}})) begin
         case_s = overflow_div;
      end else if (rem_sel) begin
         case_s = normal_rem;
      end else begin
         case_s = normal_div;
      end
   end

   // Final sign fix and result selection, valid on the last RUN cycle.
   always_comb begin
      quo_nxt_s = {quo_r[XLEN-3:0], step_q_s};
      q_fix_s   = neg_q_r ? -quo_nxt_s[XLEN-1:0] : quo_nxt_s[XLEN-1:0];
      r_fix_s   = neg_r_r ? -step_rem_s[XLEN-1:0] : step_rem_s[XLEN-1:0];
      case (case_r)
         normal_div:   res_s = q_fix_s;
         normal_rem:   res_s = r_fix_s;
         div_by_0_div: res_s = rem_sel_r ? dvd_r : {XLEN{1'b1}};
         overflow_div: res_s = rem_sel_r ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
         default:      res_s = {XLEN{1'b0}};
      endcase
   end

   // FSM next-state; flush always wins.
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = accept_s ? RUN : IDLE;
            RUN:     state_nxt_s = (cnt_r == 4'd1) ? FIN : RUN;
            FIN:     state_nxt_s = accept_s ? RUN : IDLE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath: operand latch on accept, one radix-8 step per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= 4'd0;
         rem_r     <= {(XLEN+1){1'b0}};
         quo_r     <= {(XLEN+1){1'b0}};
         dsr_r     <= {(XLEN+1){1'b0}};
         dvd_r     <= {XLEN{1'b0}};
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         rem_sel_r <= 1'b0;
         case_r    <= normal_div;
      end else if (flush) begin
         cnt_r <= 4'd0;
      end else if (accept_s) begin
         cnt_r     <= 4'(ITERS);
         rem_r     <= {(XLEN+1){1'b0}};
         quo_r     <= dvd_mag_s;
         dsr_r     <= dsr_mag_s;
         dvd_r     <= dividend;
         neg_q_r   <= dvd_neg_s ^ dsr_neg_s;
         neg_r_r   <= dvd_neg_s;
         rem_sel_r <= rem_sel;
         case_r    <= case_s;
      end else if (state_r == RUN) begin
         cnt_r <= cnt_r - 4'd1;
         rem_r <= step_rem_s;
         quo_r <= quo_nxt_s;
      end
   end

   // Registered handshake outputs and result hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= {XLEN{1'b0}};
      end else begin
         done_r <= last_s && !flush;
         if (last_s && !flush) begin
            result_r <= res_s;
         end
         if (flush) begin
            busy_r <= 1'b0;
         end else if (accept_s) begin
            busy_r <= 1'b1;
         end else if (last_s) begin
            busy_r <= 1'b0;
         end
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle
// sequencing/flush/reset sequences and randomized ops against an arithmetic model.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, flush, rem_sel;
   sign_t       sign;
   logic [31:0] dividend, divisor;
   logic        busy, done;
   logic [31:0] result;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_last;

   div_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .flush    (flush),
      .sign     (sign),
      .rem_sel  (rem_sel),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      sign_t       sg;
      logic        rs;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // RISC-V M semantics computed with wide signed arithmetic.
   function automatic logic [31:0] ref_div(input sign_t sg, input logic rs,
                                           input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 32'd0) return rs ? a : 32'hFFFF_FFFF;
      if (sg == signed_op) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return rs ? r[31:0] : q[31:0];
      end
      uq = a / b;
      ur = a % b;
      return rs ? ur : uq;
   endfunction

   task automatic run_op(input sign_t sg, input logic rs, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input string nm);
      @(negedge clk);
      sign = sg; rem_sel = rs; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 12; c++) begin
         check({nm, " busy"}, {31'd0, busy}, 32'd1);
         check({nm, " early done"}, {31'd0, done}, 32'd0);
         @(posedge clk); #1;
      end
      check({nm, " done@12"}, {31'd0, done}, 32'd1);
      check({nm, " busy@12"}, {31'd0, busy}, 32'd0);
      check({nm, " result"}, result, exp);
      exp_last = exp;
      @(posedge clk); #1;
      check({nm, " done pulse"}, {31'd0, done}, 32'd0);
   endtask

   task automatic flush_at(input int k);
      @(negedge clk);
      sign = signed_op; rem_sel = 1'b0; dividend = 32'hFFFF_FFF9; divisor = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         if (c == k) flush = 1'b1;
         if (c == k + 1) begin
            flush = 1'b0;
            check("flush busy drop", {31'd0, busy}, 32'd0);
         end
         check("flush no done", {31'd0, done}, 32'd0);
         @(posedge clk); #1;
      end
      check("flush result hold", result, exp_last);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; rem_sel = 1'b0;
      sign = unsigned_op; dividend = 32'd0; divisor = 32'd0; exp_last = 32'd0;

      vecs[0]  = '{unsigned_op, 1'b0, 32'd100,        32'd7,          32'd14,         "u 100/7 q"};
      vecs[1]  = '{unsigned_op, 1'b1, 32'd100,        32'd7,          32'd2,          "u 100/7 r"};
      vecs[2]  = '{signed_op,   1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "s -7/2 q"};
      vecs[3]  = '{signed_op,   1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "s -7/2 r"};
      vecs[4]  = '{signed_op,   1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  "s 7/-2 q"};
      vecs[5]  = '{signed_op,   1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          "s 7/-2 r"};
      vecs[6]  = '{unsigned_op, 1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  "u div0 q"};
      vecs[7]  = '{unsigned_op, 1'b1, 32'h1234_5678,  32'd0,          32'h1234_5678,  "u div0 r"};
      vecs[8]  = '{signed_op,   1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  "s div0 q"};
      vecs[9]  = '{signed_op,   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "s ovf q"};
      vecs[10] = '{signed_op,   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "s ovf r"};
      vecs[11] = '{unsigned_op, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "u ovf q"};
      vecs[12] = '{unsigned_op, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "u ovf r"};
      vecs[13] = '{unsigned_op, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  "u max/1 q"};
      vecs[14] = '{signed_op,   1'b1, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  "s min/3 r"};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'd0);

      for (int i = 0; i < 15; i++)
         run_op(vecs[i].sg, vecs[i].rs, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

      // start held high: accepts at T and at the FIN cycle T+12
      @(negedge clk);
      sign = unsigned_op; rem_sel = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 24; c++) begin
         check("held start done", {31'd0, done}, {31'd0, (c == 12 || c == 24)});
         check("held start busy", {31'd0, busy}, {31'd0, !(c == 12 || c == 24)});
         if (c == 12) begin
            check("held start result1", result, 32'd14);
            dividend = 32'd200;
         end
         if (c == 24) begin
            check("held start result2", result, 32'd28);
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("held start idle", {31'd0, busy}, 32'd0);
      exp_last = 32'd28;

      // start raised while busy is ignored
      @(negedge clk);
      sign = unsigned_op; rem_sel = 1'b1; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 5) begin
            start = 1'b1; dividend = 32'd999; divisor = 32'd3; rem_sel = 1'b0;
         end
         if (c == 6) start = 1'b0;
         check("ignore start done", {31'd0, done}, {31'd0, (c == 12)});
         if (c == 12) check("ignore start result", result, 32'd2);
         if (c >= 13) check("ignore start idle", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
      end
      exp_last = 32'd2;

      flush_at(6);
      flush_at(11);

      // flush together with start in IDLE is not accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush+start busy", {31'd0, busy}, 32'd0);
      run_op(unsigned_op, 1'b0, 32'd1000, 32'd10, 32'd100, "after flush");

      // reset in the middle of an operation
      @(negedge clk);
      sign = unsigned_op; rem_sel = 1'b1; dividend = 32'h1234_5678; divisor = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         if (c == 4) rst = 1'b1;
         if (c == 5) begin
            rst = 1'b0;
            check("mid rst busy", {31'd0, busy}, 32'd0);
            check("mid rst result", result, 32'd0);
         end
         check("mid rst no done", {31'd0, done}, 32'd0);
         @(posedge clk); #1;
      end
      run_op(signed_op, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "after rst");

      for (int n = 0; n < 40; n++) begin
         sign_t       sg;
         logic        rs;
         logic [31:0] a, b;
         sg = sign_t'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) b = -b;
         if ($urandom_range(0, 9) == 0) b = 32'd0;
         if ($urandom_range(0, 9) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         run_op(sg, rs, a, b, ref_div(sg, rs, a, b), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider in the execute stage. Operands arrive from decode/issue. The quotient or remainder goes back to the ALU result mux. A radix-8 restoring loop retires 3 quotient bits per cycle. The result is always returned exactly DIV_LATENCY (12) cycles after issue, including special cases, so the pipeline stall logic can be a fixed countdown.

## Interface
- XLEN, 32: operand and result width.
- BITS_PER_CYCLE, 3: quotient bits retired per iteration. Requirement: ceil((XLEN+1)/BITS_PER_CYCLE) + 1 == DIV_LATENCY.
- clk  in  1: clock. One clock domain; all state updates on its rising edge.
- rst  in  1: reset, synchronous and active-high.
- start  in  1: issue request. Accepted only when busy=0.
- flush  in  1: kills any in-flight operation (branch mispredict or trap).
- sign  in  1 (sign_t): signed_op for DIV/REM, unsigned_op for DIVU/REMU.
- rem_sel  in  1: 0 returns the quotient, 1 returns the remainder.
- dividend  in  XLEN: rs1 value, sampled on accept.
- divisor  in  XLEN: rs2 value, sampled on accept.
- busy  out  1: an operation is in flight and a new start is not accepted.
- done  out  1: single-cycle pulse; result is valid this cycle.
- result  out  XLEN: quotient or remainder; holds its value until the next done.

## Operation
- FSM states (div_state_t): IDLE, RUN, FIN.
- IDLE:
  - start=1 and flush=0 → accept. Latch operands, sign, rem_sel. Classify into div_out_case_t. Load iteration counter with 11. Go to RUN.
- RUN:
  - Each cycle, run one div_step_r8 on the 33-bit partial remainder and the magnitude divisor. Decrement the counter.
  - Counter reaches 0 → go to FIN.
- FIN:
  - Apply the sign fix, select quotient or remainder, register into result, assert done.
  - start in the FIN cycle is accepted (back-to-back); the FSM goes to RUN. Otherwise go to IDLE.
- Signed operands: iterate on magnitudes.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned operands: used raw, zero-extended to XLEN+1 bits.
- Special cases are decided at accept. The loop still runs so that latency stays fixed; the loop output is discarded.
  - div_by_0_div (divisor==0): quotient = all ones (signed and unsigned), remainder = dividend.
  - overflow_div (signed, dividend=0x8000_0000, divisor=0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0.
  - normal_div / normal_rem: computed result, selected by rem_sel.
- flush:
  - In any state, the FSM returns to IDLE on the next edge. No done is produced. result holds its old value.
  - flush together with start: flush wins and the request is not accepted.
- rst: all state is cleared, overriding everything including a mid-operation divide.

## Timing
- Accept edge is T (start=1, busy=0, flush=0).
- busy=1 during cycles T+1 … T+11. busy=0 during the FIN cycle T+12.
- done=1 and result valid in cycle T+12 only. Latency = DIV_LATENCY = 12, independent of operand values or case.
- start while busy=1 is ignored. The issuer must hold the request.
- Maximum throughput: one divide per 12 cycles, accepting at each FIN.
- Reset values: busy=0, done=0, result=0, FSM=IDLE, counter=0.
- done is a registered output. result is registered on the FIN edge and holds afterwards.

## Structure
- alu_defines additions:
  - DIV_BITS_PER_CYCLE = 3.
  - div_state_t {IDLE, RUN, FIN}.
- Reused from alu_defines: DIV_LATENCY, sign_t, div_out_case_t.
- Sub-module div_step_r8: combinational. Three chained restoring subtract/shift steps, taking (partial remainder, dividend bits, divisor magnitude) to (next remainder, 3 quotient bits).
- div_unit holds the FSM, counter, operand/sign latches, case classification, and the final sign-fix/select logic.

## Test plan
- Unsigned divide, 100 / 7:
  - rem_sel=0 → result=14 at T+12.
  - rem_sel=1 → result=2 at T+12.
  - busy high T+1..T+11.
- Signed divide, −7 / 2:
  - quotient 0xFFFF_FFFD (−3).
  - remainder 0xFFFF_FFFF (−1).
  - 7 / −2: quotient −3, remainder 1.
- Division by zero, 0x1234_5678 / 0:
  - quotient 0xFFFF_FFFF, remainder 0x1234_5678.
  - done still arrives at exactly T+12.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF:
  - DIV result 0x8000_0000, REM result 0.
  - Same opcode with sign=unsigned_op: quotient 0, remainder 0x8000_0000.
- Sequencing:
  - start held high continuously → accepts at T and T+12, done at T+12 and T+24.
  - start raised at T+5 is ignored.
- Flush and reset:
  - flush at T+6 → no done, busy=0 at T+7, result unchanged.
  - rst at T+4 → busy=0, done=0, result=0 next cycle.
  - A new start after either completes normally.
